// File: rtl/pc_next_unit.sv
// Program-counter unit: registered PC, next-PC selection for seq/branch/jump/jr,
// and a small circular return-address stack that predicts jr return targets.
`timescale 1ns/1ps

module pc_next_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         PCWre,
    input  logic [1:0]                   PCSrc,
    input  logic [15:0]                  immediate,
    input  logic [25:0]                  inAddress,
    input  logic [ADDR_W-1:0]            rs_data,
    input  logic                         link,
    input  logic                         ret,
    output logic [ADDR_W-1:0]            PC,
    output logic [ADDR_W-1:0]            PC4,
    output logic [ADDR_W-1:0]            nextPC,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_hit,
    output logic                         ras_miss
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt, top_ptr, mem_idx;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              hit_q, miss_q, hit_nxt, miss_nxt;
    logic              mem_we, empty, full, pop_en, push_en, pop_match;
    logic [ADDR_W-1:0] branch_off, jump_target, rs_aligned;

    assign PC         = pc_q;
    assign PC4        = pc_q + ADDR_W'(4);
    assign branch_off = {{(ADDR_W-18){immediate[15]}}, immediate, 2'b00};
    assign rs_aligned = rs_data & ~ADDR_W'(3);

    // Jump keeps the PC4 region bits only when the PC is wider than the 28-bit jump span.
    generate
        if (ADDR_W > 28) begin : g_region
            assign jump_target = {PC4[ADDR_W-1:28], inAddress, 2'b00};
        end else begin : g_flat
            assign jump_target = {inAddress, 2'b00};
        end
    endgenerate

    always_comb begin
        nextPC = PC4;
        case (PCSrc)
            2'b00: nextPC = PC4;
            2'b01: nextPC = PC4 + branch_off;
            2'b10: nextPC = rs_aligned;
            2'b11: nextPC = jump_target;
            default: nextPC = PC4;
        endcase
    end

    assign top_ptr   = wr_ptr - PTR_W'(1);
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(RAS_DEPTH));
    assign ras_top   = empty ? '0 : ras_mem[top_ptr];
    assign ras_count = count;
    assign ras_hit   = hit_q;
    assign ras_miss  = miss_q;
    assign pop_en    = PCWre && ret && (PCSrc == 2'b10);
    assign push_en   = PCWre && link;
    assign pop_match = (ras_mem[top_ptr] == rs_aligned);

    // A pop+push on a non-empty stack replaces the top slot in place; otherwise a
    // push always advances the pointer and overwrites the oldest entry when full.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        hit_nxt    = 1'b0;
        miss_nxt   = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = wr_ptr;
        if (pop_en && !empty) begin
            hit_nxt  = pop_match;
            miss_nxt = !pop_match;
            if (push_en) begin
                mem_we  = 1'b1;
                mem_idx = top_ptr;
            end else begin
                wr_ptr_nxt = top_ptr;
                count_nxt  = count - CNT_W'(1);
            end
        end else begin
            if (pop_en) begin
                miss_nxt = 1'b1;
            end
            if (push_en) begin
                mem_we     = 1'b1;
                mem_idx    = wr_ptr;
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
                if (!full) begin
                    count_nxt = count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q   <= RESET_PC;
            wr_ptr <= '0;
            count  <= '0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            if (PCWre) begin
                pc_q <= nextPC;
            end
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
            hit_q  <= hit_nxt;
            miss_q <= miss_nxt;
        end
    end

    // Stack storage is not reset; ras_top is masked to zero while the count is zero.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            ras_mem[mem_idx] <= PC4;
        end
    end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter unit for the multi-cycle CPU. It holds the PC register and computes the next PC for four modes: sequential, branch, jump and jump-register. It also keeps a small circular return-address stack (RAS) that checks each `jr` return target against the stack prediction. It generalises the fixed 32-bit jump-address former into a registered, width- and depth-configurable block driven by the control unit's `PCWre`/`PCSrc`.

## Interface
Parameters:
- `ADDR_W`, 32, PC width. Legal range 28..32; upper bits `[ADDR_W-1:28]` exist only when `ADDR_W` > 28.
- `RESET_PC`, 0, PC value loaded on reset. Must be word-aligned.
- `RAS_DEPTH`, 4, number of RAS entries. Must be a power of two, at least 2.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `PCWre`  in  1  PC write enable; no state changes when 0.
- `PCSrc`  in  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump-register, 11 = jump.
- `immediate`  in  16  branch offset in words, sign-extended.
- `inAddress`  in  26  jump target field.
- `rs_data`  in  ADDR_W  register operand for jump-register.
- `link`  in  1  push PC+4 onto the RAS (jal / jalr).
- `ret`  in  1  pop the RAS; only honoured when `PCSrc` = 10.
- `PC`  out  ADDR_W  current PC (registered).
- `PC4`  out  ADDR_W  PC+4 (combinational).
- `nextPC`  out  ADDR_W  candidate next PC (combinational).
- `ras_top`  out  ADDR_W  top RAS entry; 0 when the stack is empty.
- `ras_count`  out  clog2(RAS_DEPTH)+1  number of valid entries.
- `ras_hit`  out  1  registered one-cycle pulse: the popped entry equalled `rs_data`.
- `ras_miss`  out  1  registered one-cycle pulse: the pop mismatched, or the stack was empty.

## Operation
- `PC4` = `PC` + 4, taken modulo 2^ADDR_W.
- Branch: `nextPC` = `PC4` + (sext(`immediate`) << 2), truncated to `ADDR_W`.
- Jump: `nextPC` = {`PC4`[ADDR_W-1:28], `inAddress`, 2'b00}. When `ADDR_W` = 28 this is {`inAddress`, 00}.
- Jump-register: `nextPC` = `rs_data` with bits [1:0] forced to 00.
- On a rising edge with `PCWre` = 1:
  - `PC` <= `nextPC`.
  - RAS operations are evaluated in the same cycle.
- Push (`link` = 1): write `PC4` at the write pointer, then increment the pointer.
  - Count saturates at `RAS_DEPTH`.
  - Pushing when full overwrites the oldest entry (circular wrap).
- Pop (`ret` = 1 and `PCSrc` = 10):
  - Non-empty: compare the top entry to `rs_data` (bits [1:0] masked), pulse `ras_hit` or `ras_miss`, then decrement the pointer and count.
  - Empty: pulse `ras_miss`; pointer and count stay unchanged.
- `ret` with `PCSrc` != 10 is ignored, with no flags.
- Simultaneous pop and push: the pop compare uses the old top, then the new `PC4` replaces that slot. Pointer and count are unchanged. If the stack was empty, it is a miss plus a push (count becomes 1).
- With `PCWre` = 0, `link` and `ret` are ignored.
- Reset, asserted at any time including mid-instruction:
  - `PC` = `RESET_PC`
  - pointer = 0, count = 0
  - `ras_hit` = `ras_miss` = 0
  - RAS contents need not be cleared; `ras_top` reads 0 whenever count = 0.

## Timing
- Zero-cycle combinational paths: `PC4`, `nextPC`, `ras_top`.
- `PC`, `ras_count`, `ras_hit` and `ras_miss` update one cycle after the `PCWre` edge.
- `ras_hit` and `ras_miss` are high for exactly the one cycle after the pop edge, are mutually exclusive, and are cleared on the next edge regardless of `PCWre`.
- The control unit holds `PCSrc`, `link` and `ret` stable while `PCWre` = 1. Only one edge per instruction is qualified.
- Reset deassertion is synchronous to `CLK` at the system level. The first update happens on the first edge with `PCWre` = 1 after release.

## Test plan
- Reset with `RESET_PC` = 0x0000_3000 -> `PC` = 0x3000, `ras_count` = 0, `ras_top` = 0. Then 3 sequential edges -> `PC` = 0x300C.
- `PC` = 0x1000_0040, `PCSrc` = 11, `inAddress` = 0x0000100 -> `PC` = 0x1000_0400. Branch from 0x0040 with `immediate` = 0xFFFF -> `PC` = 0x0040. Wrap check: `PC` = 0xFFFF_FFFC, sequential -> 0x0.
- jal at 0x100 (push 0x104), then `PCSrc` = 10, `ret` = 1, `rs_data` = 0x104 -> `PC` = 0x104, `ras_hit` pulses for one cycle, `ras_count` returns to 0.
- `RAS_DEPTH` = 4: push 5 times (0x4, 0x8, 0xC, 0x10, 0x14) -> count saturates at 4, `ras_top` = 0x14. Pop 4 times matching -> all hits; 0x4 has been lost, so a fifth pop with `rs_data` = 0x4 -> `ras_miss`, count stays 0.
- Simultaneous `link` + `ret` with top = 0x200, `rs_data` = 0x200, `PC4` = 0x84 -> `ras_hit`, count unchanged, `ras_top` = 0x84. Also `PCWre` = 0 with `link` = 1 -> no change to `PC` or RAS.
- Assert `Reset` asynchronously mid-cycle with count = 3 and `ras_miss` high -> `PC`, count and flags clear immediately, without waiting for a `CLK` edge.
